// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared types for the instruction register and its controller
package instr_register_pkg;

   localparam int DEPTH_DEFAULT = 32;

   typedef enum logic [3:0] {
      ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
   } opcode_t;

   typedef logic signed [31:0] operand_t;
   typedef logic [$clog2(DEPTH_DEFAULT)-1:0] address_t;
   typedef logic req_id_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

endpackage

// File: rtl/instr_register_ctrl_if.sv
// rtl/instr_register_ctrl_if.sv - requester, register and consumer signals of the controller
interface instr_register_ctrl_if
   import instr_register_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int PTR_W = $clog2(DEPTH)
) ();

   logic         req0_valid;
   logic         req0_ready;
   opcode_t      req0_opcode;
   operand_t     req0_operand_a;
   operand_t     req0_operand_b;
   logic         req1_valid;
   logic         req1_ready;
   opcode_t      req1_opcode;
   operand_t     req1_operand_a;
   operand_t     req1_operand_b;
   logic         load_en;
   logic [PTR_W-1:0] write_pointer;
   opcode_t      opcode;
   operand_t     operand_a;
   operand_t     operand_b;
   logic [PTR_W-1:0] read_pointer;
   instruction_t instruction_word;
   logic         out_valid;
   logic         out_ready;
   instruction_t out_instr;
   logic [PTR_W:0] count;

   modport master (
      input  req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
      output req0_ready,
      input  req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
      output req1_ready,
      output load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
      input  instruction_word,
      output out_valid, out_instr, count,
      input  out_ready
   );

   modport slave (
      output req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
      input  req0_ready,
      output req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
      input  req1_ready,
      input  load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
      output instruction_word,
      input  out_valid, out_instr, count,
      output out_ready
   );

endinterface

// File: rtl/instr_register.sv
// rtl/instr_register.sv - instruction storage array with synchronous write and combinational read
module instr_register
   import instr_register_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] write_pointer,
   input  opcode_t                  opcode,
   input  operand_t                 operand_a,
   input  operand_t                 operand_b,
   input  logic [$clog2(DEPTH)-1:0] read_pointer,
   output instruction_t             instruction_word
);

   instruction_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b};
      end
   end

   assign instruction_word = mem[read_pointer];

endmodule

// File: rtl/instr_rr_arbiter.sv
// rtl/instr_rr_arbiter.sv - two-way round-robin arbiter with one-hot grant
module instr_rr_arbiter
   import instr_register_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] valid,
   input  logic       block,
   output logic [1:0] grant
);

   req_id_t last_grant;

   always_comb begin
      grant = 2'b00;
      if (!block) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // A grant is only ever issued to a valid requester, so every grant is an accepted push.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant <= 1'b1;
      end else if (grant != 2'b00) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/instr_register_ctrl.sv
// rtl/instr_register_ctrl.sv - arbitrates two producers into the instruction register, reads it in FIFO order
module instr_register_ctrl
   import instr_register_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   instr_register_ctrl_if.master bus
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wp;
   logic [PTR_W-1:0] rp;
   logic [PTR_W:0]   cnt;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [1:0]       valid;
   logic [1:0]       grant;

   assign full  = (cnt == (PTR_W+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign valid = {bus.req1_valid, bus.req0_valid};

   // Holding the arbiter off during reset keeps any handshake from completing in that cycle.
   instr_rr_arbiter u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .valid   (valid),
      .block   (full || !reset_n),
      .grant   (grant)
   );

   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];
   assign push           = |(grant & valid);
   assign bus.load_en    = push;

   always_comb begin
      bus.opcode    = ZERO;
      bus.operand_a = '0;
      bus.operand_b = '0;
      if (grant[0]) begin
         bus.opcode    = bus.req0_opcode;
         bus.operand_a = bus.req0_operand_a;
         bus.operand_b = bus.req0_operand_b;
      end else if (grant[1]) begin
         bus.opcode    = bus.req1_opcode;
         bus.operand_a = bus.req1_operand_a;
         bus.operand_b = bus.req1_operand_b;
      end
   end

   assign bus.write_pointer = wp;
   assign bus.read_pointer  = rp;
   assign bus.out_valid     = !empty && reset_n;
   assign bus.out_instr     = bus.instruction_word;
   assign bus.count         = cnt;
   assign pop               = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule
